// File: rtl/vram_rect_writer.sv
// Fills a rectangle of video RAM with a constant word, one registered write per clock.
// Commands are taken over a valid/ready handshake in IDLE. A one-cycle done pulse follows the
// last write. An abort ends the fill early and produces no done pulse.
module vram_rect_writer #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [DIM_W-1:0]  cmd_width,
  input  logic [DIM_W-1:0]  cmd_height,
  input  logic [DIM_W-1:0]  cmd_pitch,
  input  logic [DATA_W-1:0] cmd_value,
  input  logic              abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StWrite, StFinish} state_e;

  state_e            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [ADDR_W-1:0] row_start_q, row_start_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [DIM_W-1:0]  pitch_q, pitch_d;
  logic [ADDR_W-1:0] next_row_start;

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign next_row_start = row_start_q + ADDR_W'(pitch_q);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      row_start_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      width_q     <= '0;
      height_q    <= '0;
      pitch_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      row_start_q <= row_start_d;
      col_q       <= col_d;
      row_q       <= row_d;
      width_q     <= width_d;
      height_q    <= height_d;
      pitch_q     <= pitch_d;
    end
  end

  // Next-state logic: accept, raster walk (col inner, row outer), abort, finish.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    row_start_d = row_start_q;
    col_d       = col_q;
    row_d       = row_q;
    width_d     = width_q;
    height_d    = height_q;
    pitch_d     = pitch_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          width_d     = cmd_width;
          height_d    = cmd_height;
          pitch_d     = cmd_pitch;
          col_d       = '0;
          row_d       = '0;
          row_start_d = cmd_base;
          if (cmd_width == '0 || cmd_height == '0) begin
            state_d = StFinish;
          end else begin
            // First write is presented the cycle after accept.
            state_d    = StWrite;
            mem_we_d   = 1'b1;
            mem_addr_d = cmd_base;
            mem_din_d  = cmd_value;
          end
        end
      end
      StWrite: begin
        if (abort) begin
          mem_we_d = 1'b0;
          state_d  = StIdle;
        end else if (col_q != width_q - DIM_W'(1)) begin
          col_d      = col_q + DIM_W'(1);
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end else if (row_q != height_q - DIM_W'(1)) begin
          col_d       = '0;
          row_d       = row_q + DIM_W'(1);
          row_start_d = next_row_start;
          mem_addr_d  = next_row_start;
        end else begin
          mem_we_d = 1'b0;
          state_d  = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q == StWrite);
  assign done      = (state_q == StFinish);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

endmodule
